// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
//   - Default datapath width.
//   - 3-bit state encoding: IDLE, MULT, DIV, FIXUP, DONE.
//   - Radix-2 Booth pair codes, i.e. {q0, q(-1)}.
package multdiv_pkg;

  localparam int unsigned MultdivDataW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMult  = 3'd1,
    StDiv   = 3'd2,
    StFixup = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [1:0] BoothAdd = 2'b01;
  localparam logic [1:0] BoothSub = 2'b10;

endpackage

// File: rtl/multdiv_cneg.sv
// Combinational conditional two's-complement negate.
// Ports:
//   data_i - operand
//   neg_i  - when 1 the output is -data_i, otherwise data_i
//   data_o - result
module multdiv_cneg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              neg_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = neg_i ? -data_i : data_i;

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle multiply/divide engine for the HI/LO datapath.
// Multiply uses radix-2 Booth. Divide uses restoring division on magnitudes.
// Each iteration handles one bit per cycle. The control unit stalls while busy is high.
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   start_mult, start_div   - one-cycle start pulses; multiply wins if both are high
//   op_a, op_b              - operands from registers A and B
//   op_unsigned             - (MULTDIV_UNSIGNED_EN only) selects multu/divu
//   busy                    - high in MULT, DIV and FIXUP
//   done                    - one-cycle completion pulse
//   div_zero                - coincides with done on divide by zero
//   hi_out, lo_out          - high word/remainder, low word/quotient
//   hi_we, lo_we            - HI/LO write strobes; coincide with a normal done
// Optional build macro: MULTDIV_UNSIGNED_EN adds the op_unsigned input.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W = MultdivDataW,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic              op_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hi_we,
  output logic              lo_we
);

  state_e              state_q, state_d;
  logic [DATA_W:0]     acc_hi_q, acc_hi_d;   // Booth upper half / partial remainder
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;   // multiplier / dividend-then-quotient
  logic                qm1_q, qm1_d;         // Booth q(-1)
  logic [DATA_W:0]     mcand_q, mcand_d;     // extended multiplicand / divisor magnitude
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MULTDIV_UNSIGNED_EN
  logic                umul_fix_q, umul_fix_d;
`endif

  logic                signed_op;
  logic [DATA_W-1:0]   abs_a, abs_b, fix_q, fix_r, mult_hi;
  logic [DATA_W:0]     booth_sum, div_shift;
  logic [DATA_W+1:0]   div_trial;
  logic                cnt_last;

`ifdef MULTDIV_UNSIGNED_EN
  assign signed_op = ~op_unsigned;
  // In unsigned mode, a multiplier with its MSB set was treated by Booth as
  // b - 2**DATA_W. This adds the missing a * 2**DATA_W back into the high word.
  assign mult_hi   = acc_hi_q[DATA_W-1:0] + (umul_fix_q ? mcand_q[DATA_W-1:0] : '0);
`else
  assign signed_op = 1'b1;
  assign mult_hi   = acc_hi_q[DATA_W-1:0];
`endif

  multdiv_cneg #(.DATA_W(DATA_W)) u_abs_a (
    .data_i (op_a),
    .neg_i  (signed_op & op_a[DATA_W-1]),
    .data_o (abs_a)
  );

  multdiv_cneg #(.DATA_W(DATA_W)) u_abs_b (
    .data_i (op_b),
    .neg_i  (signed_op & op_b[DATA_W-1]),
    .data_o (abs_b)
  );

  multdiv_cneg #(.DATA_W(DATA_W)) u_fix_q (
    .data_i (acc_lo_q),
    .neg_i  (q_neg_q),
    .data_o (fix_q)
  );

  multdiv_cneg #(.DATA_W(DATA_W)) u_fix_r (
    .data_i (acc_hi_q[DATA_W-1:0]),
    .neg_i  (r_neg_q),
    .data_o (fix_r)
  );

  always_comb begin
    booth_sum = acc_hi_q;
    case ({acc_lo_q[0], qm1_q})
      BoothAdd: booth_sum = acc_hi_q + mcand_q;
      BoothSub: booth_sum = acc_hi_q - mcand_q;
      default:  ;
    endcase
  end

  // The trial subtract is one bit wider than the remainder. Unsigned divisors
  // near 2**DATA_W can push the shifted remainder into bit DATA_W.
  assign div_shift = {acc_hi_q[DATA_W-1:0], acc_lo_q[DATA_W-1]};
  assign div_trial = {1'b0, div_shift} - {1'b0, mcand_q};
  assign cnt_last  = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULTDIV_UNSIGNED_EN
    umul_fix_d = umul_fix_q;
`endif

    case (state_q)
      StMult: begin
        acc_hi_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
        acc_lo_d = {booth_sum[0], acc_lo_q[DATA_W-1:1]};
        qm1_d    = acc_lo_q[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_last) state_d = StFixup;
      end
      StDiv: begin
        if (!div_trial[DATA_W+1]) begin
          acc_hi_d = div_trial[DATA_W:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift;
          acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) state_d = StFixup;
      end
      StFixup: begin
        if (is_div_q) begin
          lo_d = fix_q;
          hi_d = fix_r;
        end else begin
          hi_d = mult_hi;
          lo_d = acc_lo_q;
        end
        state_d = StDone;
      end
      // A new start is accepted in DONE as well, since busy is already low there.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_mult) begin
          acc_hi_d = '0;
          acc_lo_d = op_b;
          qm1_d    = 1'b0;
          mcand_d  = {signed_op & op_a[DATA_W-1], op_a};
          cnt_d    = '0;
          is_div_d = 1'b0;
          dz_d     = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
          umul_fix_d = op_unsigned & op_b[DATA_W-1];
`endif
          state_d  = StMult;
        end else if (start_div) begin
          if (op_b != '0) begin
            acc_hi_d = '0;
            acc_lo_d = abs_a;
            mcand_d  = {1'b0, abs_b};
            cnt_d    = '0;
            is_div_d = 1'b1;
            q_neg_d  = signed_op & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            r_neg_d  = signed_op & op_a[DATA_W-1];
            dz_d     = 1'b0;
            state_d  = StDiv;
          end else begin
            dz_d    = 1'b1;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULTDIV_UNSIGNED_EN
      umul_fix_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULTDIV_UNSIGNED_EN
      umul_fix_q <= umul_fix_d;
`endif
    end
  end

  assign busy     = (state_q == StMult) || (state_q == StDiv) || (state_q == StFixup);
  assign done     = (state_q == StDone);
  assign div_zero = done & dz_q;
  assign hi_we    = done & ~dz_q;
  assign lo_we    = done & ~dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer (DATA_W = 32).
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  int   done_cyc, busy_cnt, done_cnt, we_cnt;
  logic dz_at_done, hiwe_at_done, lowe_at_done;

  multdiv_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MULTDIV_UNSIGNED_EN
    .op_unsigned(1'b0),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .hi_we      (hi_we),
    .lo_we      (lo_we)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse the requested starts, then observe 40 cycles. Interval 1 is the
  // cycle right after the start edge. Operands are scrambled mid-operation.
  // Optionally start_div is re-pulsed at interval inj_div_at.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input int inj_div_at);
    @(negedge clock);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    done_cyc = 0; busy_cnt = 0; done_cnt = 0; we_cnt = 0;
    dz_at_done = 1'b0; hiwe_at_done = 1'b0; lowe_at_done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cnt++;
      if (hi_we || lo_we) we_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc     = i;
          dz_at_done   = div_zero;
          hiwe_at_done = hi_we;
          lowe_at_done = lo_we;
        end
      end
      if (i == 5) begin
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0BAD_F00D;
      end
      start_div = (i == inj_div_at);
      @(negedge clock);
    end
    start_div = 1'b0;
  endtask

  task automatic check_normal(input string tag, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
    check_val({tag, "_done_cyc"}, 32'(done_cyc), 32'd34);
    check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_val({tag, "_strobes"}, {29'd0, hiwe_at_done, lowe_at_done, dz_at_done}, 32'b110);
    check_val({tag, "_hi"}, hi_out, exp_hi);
    check_val({tag, "_lo"}, lo_out, exp_lo);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_val("reset_flags", {27'd0, busy, done, div_zero, hi_we, lo_we}, 32'd0);
    check_val("reset_hi", hi_out, 32'd0);
    check_val("reset_lo", lo_out, 32'd0);
    reset = 1'b1;

    // 7 * -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    check_val("mul_busy_cnt", 32'(busy_cnt), 32'd33);
    check_normal("mul_7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // -7 / 2 = -3 rem -1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    check_val("div_busy_cnt", 32'(busy_cnt), 32'd33);
    check_normal("div_-7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // 7 / -2 = -3 rem 1
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    check_normal("div_7/-2", 32'd1, 32'hFFFF_FFFD);

    // Preload hi=0x11, lo=0x22: 0x2211 / 0x100
    run_op(1'b0, 1'b1, 32'h0000_2211, 32'h0000_0100, 0);
    check_normal("preload", 32'h11, 32'h22);

    // Divide by zero
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    check_val("dz_done_cyc", 32'(done_cyc), 32'd1);
    check_val("dz_done_cnt", 32'(done_cnt), 32'd1);
    check_val("dz_strobes", {29'd0, hiwe_at_done, lowe_at_done, dz_at_done}, 32'b001);
    check_val("dz_we_cnt", 32'(we_cnt), 32'd0);
    check_val("dz_busy_cnt", 32'(busy_cnt), 32'd0);
    check_val("dz_hi", hi_out, 32'h11);
    check_val("dz_lo", lo_out, 32'h22);

    // Most-negative corners
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_normal("div_ovf", 32'd0, 32'h8000_0000);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_normal("mul_ovf", 32'd0, 32'h8000_0000);

    // start_div during a multiply is ignored
    run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 10);
    check_normal("mul_inj_div", 32'd0, 32'h0001_2340);

    // Both starts together: multiply wins (a divide would give lo=0, hi=3)
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 0);
    check_normal("both_starts", 32'd0, 32'd12);

    // Reset at interval 15 of a divide
    @(negedge clock);
    start_div = 1'b1;
    op_a      = 32'd100;
    op_b      = 32'd7;
    @(negedge clock);
    start_div = 1'b0;
    repeat (14) @(negedge clock);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("rst_mid_flags", {27'd0, busy, done, div_zero, hi_we, lo_we}, 32'd0);
    check_val("rst_mid_hi", hi_out, 32'd0);
    check_val("rst_mid_lo", lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || hi_we || lo_we) done_cnt++;
      @(negedge clock);
    end
    check_val("rst_no_pulses", 32'(done_cnt), 32'd0);

    run_op(1'b1, 1'b0, 32'd5, 32'd6, 0);
    check_normal("mul_5x6", 32'd0, 32'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle signed multiply/divide engine and sequencer for the HI/LO datapath.
- Accepts a one-cycle start pulse from control_unit with operands taken from registers A and B.
- Iterates one bit per cycle and writes HI/LO through its own write strobes.
- Replaces the combinational mult/div feeding the Div/MultCtrl muxes; control_unit stalls on busy.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_mult  in  1  one-cycle pulse: begin signed multiply op_a*op_b.
- start_div  in  1  one-cycle pulse: begin signed divide op_a/op_b.
- op_a  in  DATA_W  multiplicand / dividend (register A).
- op_b  in  DATA_W  multiplier / divisor (register B).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with done, on divide by zero.
- hi_out  out  DATA_W  product high word / remainder.
- lo_out  out  DATA_W  product low word / quotient.
- hi_we  out  1  HI register write enable; one cycle, coincident with done.
- lo_we  out  1  LO register write enable; one cycle, coincident with done.

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; internal accumulators and counter 0. Takes effect immediately, including mid-operation. Any partial result is discarded and no write strobe is issued.
- States: IDLE, MULT, DIV, FIXUP, DONE.
- IDLE:
  - start_mult: latch op_a and op_b, clear the accumulator and Booth bit q(-1), counter=0, go to MULT.
  - start_div with op_b!=0: latch |op_a| and |op_b|, record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)), go to DIV.
  - start_div with op_b==0: go to DONE with the zero flag set.
  - Both starts high together: multiply wins; start_div is dropped.
- MULT: radix-2 Booth, one step per cycle. Look at the pair {q0, q(-1)}: 01 adds the multiplicand to the upper half, 10 subtracts it. Then arithmetic-shift the 2*DATA_W+1 accumulator right by 1. Go to FIXUP after exactly DATA_W steps (counter == DATA_W-1).
- DIV: restoring division on magnitudes, one quotient bit per cycle, using a DATA_W+1 bit remainder. Go to FIXUP after DATA_W steps.
- FIXUP:
  - Multiply: load hi_out/lo_out from the accumulator.
  - Divide: conditionally negate the quotient and remainder by their recorded signs, load lo_out=quotient and hi_out=remainder.
  - Go to DONE.
- DONE: lasts one cycle.
  - Normal completion: done=1, hi_we=1, lo_we=1.
  - Divide-by-zero path: done=1, div_zero=1, hi_we=lo_we=0, and hi_out/lo_out keep their previous values.
  - Always returns to IDLE.
- Latency, counted in rising edges after the start edge:
  - Normal operation: done is high during edge-interval DATA_W+2 (34 cycles for 32-bit).
  - Divide by zero: done is high in the cycle immediately after start.
- busy: 1 in MULT, DIV and FIXUP, and 0 in DONE, so control_unit may issue the next start in the DONE cycle.
- Starts received while busy=1 are ignored with no side effects; operand changes during an operation are ignored.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1 (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, no flag.
  - Most-negative multiplicand is handled by the DATA_W+1 bit Booth add.
- hi_out/lo_out hold their value between operations.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- Defined: adds input port op_unsigned (1 bit), sampled together with the start pulse.
  - When 1, the engine runs multu/divu: no sign fixup, operands zero-extended to DATA_W+1.
  - For unsigned divide, 0x80000000/0xFFFFFFFF gives lo=0, hi=0x80000000.
- Undefined: the port is absent and all operations are signed.
- Latency is identical in both builds.

Decomposition:
- Package multdiv_pkg:
  - state encoding localparams for IDLE, MULT, DIV, FIXUP, DONE (3 bits);
  - DATA_W default;
  - Booth pair codes.
- Sub-module multdiv_cneg: combinational conditional two's-complement negate (in, neg flag -> out), DATA_W wide. It is instantiated for the operand absolute values and for the quotient/remainder fixup.
- Everything else stays in one sequential module.

Test Plan:
- Signed multiply:
  - Stimulus: start_mult, op_a=7, op_b=0xFFFFFFFD (-3).
  - Response: busy high for 33 cycles; done, hi_we and lo_we high at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed divide:
  - Stimulus: start_div, op_a=0xFFFFFFF9 (-7), op_b=2.
  - Response: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- Divide by zero:
  - Stimulus: preload hi=0x11, lo=0x22; then start_div with op_b=0.
  - Response: next cycle done=1 and div_zero=1; hi_we=lo_we=0; hi/lo still 0x11/0x22; busy never rises.
- Overflow corner:
  - Stimulus 1: op_a=0x80000000, op_b=0xFFFFFFFF, divide. Response: lo=0x80000000, hi=0.
  - Stimulus 2: same operands, multiply. Response: hi=0, lo=0x80000000.
- Protocol:
  - Stimulus 1: start_div pulsed at cycle 10 of a multiply. Response: ignored; the multiply result is correct; exactly one done pulse.
  - Stimulus 2: start_mult and start_div in the same cycle. Response: a multiply is performed.
- Reset mid-operation:
  - Stimulus 1: reset=0 for 1 cycle at cycle 15 of a divide. Response: all outputs 0 immediately; no done or we pulses afterwards.
  - Stimulus 2: a subsequent 5*6 multiply. Response: hi=0, lo=30.
